sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares the single SRAM-like memory port between instruction fetch (inst_*) and
//  execute-stage data access (data_*), which use the same req/addr_ok/data_ok handshake.
//  Grants one address phase per cycle and tracks outstanding transactions in an owner
//  FIFO, so each in-order mem_data_ok goes back to the requester that issued it.
//  Sits between the CPU stages and the memory/AXI bridge.
// PARAMETERS
//  OUTSTANDING  2  max accepted-but-unanswered transactions (owner FIFO depth, 1..4)
// PORTS
//  clk           in   1   clock
//  resetn        in   1   reset, synchronous, active-low
//  inst_req      in   1   fetch request (read only)
//  inst_addr     in   32  fetch address
//  inst_addr_ok  out  1   fetch address accepted
//  inst_data_ok  out  1   fetch data valid
//  inst_rdata    out  32  fetch data
//  data_req      in   1   data request
//  data_wr       in   1   1=store, 0=load
//  data_size     in   2   0=byte, 1=half, 2=word
//  data_addr     in   32  data address
//  data_wen      in   4   byte write enables (store only)
//  data_wdata    in   32  store data
//  data_addr_ok  out  1   data address accepted
//  data_data_ok  out  1   load data valid / store complete
//  data_rdata    out  32  load data
//  mem_req       out  1   request to memory
//  mem_wr        out  1   write flag to memory
//  mem_size      out  2   size to memory
//  mem_addr      out  32  address to memory
//  mem_wen       out  4   byte enables to memory
//  mem_wdata     out  32  write data to memory
//  mem_addr_ok   in   1   memory accepted address
//  mem_data_ok   in   1   memory returns response (strictly in order)
//  mem_rdata     in   32  memory read data
// BEHAVIOUR
//  - Grant FSM, states IDLE, HOLD_I and HOLD_D.
//    IDLE: pick a requester by priority.
//      If mem_addr_ok is high the same cycle, stay in IDLE.
//      If not, go to HOLD_I or HOLD_D for the requester that was offered.
//    HOLD_x: only x is offered.
//      A new request from the other side cannot preempt it.
//      Return to IDLE on mem_addr_ok, or if x_req drops.
//  - Priority: data over inst (fixed).
//  - mem_req = (granted requester's req) & ~fifo_full.
//    Full blocks the request even if a pop happens the same cycle.
//  - mem_* payload is muxed from the granted side. For inst: mem_wr=0, mem_size=2, mem_wen=0.
//  - x_addr_ok = mem_addr_ok & mem_req & grant==x. Combinational, 0-cycle pass-through.
//  - Owner FIFO: push the owner bit on mem_req & mem_addr_ok.
//    Pop on mem_data_ok. The head entry routes data_ok and rdata.
//    Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo OUTSTANDING.
//  - x_data_ok = mem_data_ok & ~fifo_empty & head==x.
//    x_rdata = mem_rdata for both sides (valid only with data_ok).
//  - mem_data_ok while the FIFO is empty: ignored, no pop, no data_ok.
//  - Reset (any cycle, including mid-transaction):
//    state=IDLE; FIFO count, pointers and priority state cleared.
//    All *_ok outputs are 0 and mem_req=0 during reset and the cycle after it.
//    In-flight responses are dropped through the empty-FIFO rule.
//  - Same-cycle accept and response: response routing uses the head before the push.
// CONFIGURATION
//  ARB_RR_EN defined:
//    Round-robin priority in IDLE. A 1-bit last-granted register is updated on every
//    accepted address. When both request, the side not granted last wins.
//    Reset value of last-granted = data, so inst wins the first tie.
//  ARB_RR_EN undefined:
//    Fixed data-over-inst priority; no priority register.
//  HOLD behaviour and the FIFO are identical in both builds.
// TESTING
//  1 Both req in the same cycle, addr_ok=1, fixed build -> data_addr_ok=1, inst_addr_ok=0.
//    Inst is accepted next cycle.
//  2 Inst offered, addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays
//    inst_addr until accepted; data is granted only after that.
//  3 OUTSTANDING=2: two inst accepted, no data_ok -> mem_req=0 with a third request pending.
//    One mem_data_ok -> inst_data_ok=1, and the third request is issued the next cycle.
//  4 Data load at 0x100 accepted, then inst at 0x200; responses 0xAAAA, then 0xBBBB ->
//    data_data_ok with 0xAAAA, then inst_data_ok with 0xBBBB.
//  5 resetn=0 with 2 outstanding, then a stray mem_data_ok after release -> no *_data_ok;
//    the next request is accepted normally.
//  6 ARB_RR_EN, both req every cycle, addr_ok=1 -> grants alternate I,D,I,D starting with inst.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
//
// Purpose:
//   Shares one SRAM-like memory port between instruction fetch (inst_*) and
//   execute-stage data access (data_*). One address phase is granted per cycle.
//   Every accepted address pushes its owner into a small owner FIFO, and each
//   in-order mem_data_ok is routed back to the requester at the FIFO head.
//
// Parameters:
//   OUTSTANDING  max accepted-but-unanswered transactions (owner FIFO depth, 1..4)
//
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   inst_req/addr                     fetch request (read only)
//   inst_addr_ok/data_ok/rdata        fetch handshake back to the fetch stage
//   data_req/wr/size/addr/wen/wdata   data request from the execute stage
//   data_addr_ok/data_ok/rdata        data handshake back to the execute stage
//   mem_req/wr/size/addr/wen/wdata    request to the memory / AXI bridge
//   mem_addr_ok/data_ok/rdata         memory handshake (responses strictly in order)
//
// Build option:
//   ARB_RR_EN  when defined, ties in IDLE are broken round-robin using a 1-bit
//              last-granted register (reset to data, so inst wins the first tie).
//              When undefined, data always beats inst.
// -----------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction fetch side
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data access side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // memory side
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              out_en_q;
    logic              en;
    logic              idle_pick_data;
    logic              grant_data;
    logic              grant_req;
    logic              accept;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_data;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              owner_q [OUTSTANDING];   // 1 = data owns the slot
    logic [OUTSTANDING-1:0] slot_we;

    // Outputs are forced quiet while reset is asserted and for one cycle after
    // release, so stale requests cannot slip through before the FIFO is clean.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
        end
    end

    assign en = resetn & out_en_q;

    // ------------------------------------------------------------------
    // Priority choice used only in IDLE
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    logic last_data_q, last_data_d;

    always_comb begin
        if (inst_req && data_req) begin
            idle_pick_data = ~last_data_q;
        end else begin
            idle_pick_data = data_req;
        end
    end

    assign last_data_d = accept ? grant_data : last_data_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    // Data wins any tie; with no data request the inst side is offered.
    assign idle_pick_data = data_req;
`endif

    // ------------------------------------------------------------------
    // Grant FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Offered but not taken: lock onto that requester.
                if (mem_req && !mem_addr_ok) begin
                    state_d = grant_data ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I: begin
                if (accept || !inst_req) begin
                    state_d = IDLE;
                end
            end
            HOLD_D: begin
                if (accept || !data_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant FSM: outputs (grant select and memory payload mux)
    // ------------------------------------------------------------------
    always_comb begin
        case (state_q)
            HOLD_I:  grant_data = 1'b0;
            HOLD_D:  grant_data = 1'b1;
            default: grant_data = idle_pick_data;
        endcase

        grant_req = grant_data ? data_req : inst_req;
        // A full FIFO blocks the request even if a pop lands this cycle.
        mem_req   = en & grant_req & ~fifo_full;

        mem_wr    = grant_data & data_wr;
        mem_size  = grant_data ? data_size  : 2'd2;
        mem_addr  = grant_data ? data_addr  : inst_addr;
        mem_wen   = grant_data ? data_wen   : 4'b0000;
        mem_wdata = grant_data ? data_wdata : 32'd0;

        inst_addr_ok = mem_addr_ok & mem_req & ~grant_data;
        data_addr_ok = mem_addr_ok & mem_req &  grant_data;
    end

    assign accept = mem_req & mem_addr_ok;

    // ------------------------------------------------------------------
    // Owner FIFO
    // ------------------------------------------------------------------
    assign fifo_full  = (count_q == DEPTH);
    assign fifo_empty = (count_q == '0);
    assign head_data  = owner_q[rd_ptr_q];

    // Responses with nothing outstanding are stray and simply dropped.
    assign pop = en & mem_data_ok & ~fifo_empty;

    // Routing uses the head as it stands before any same-cycle push.
    assign inst_data_ok = pop & ~head_data;
    assign data_data_ok = pop &  head_data;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUTSTANDING; gi++) begin : g_slot
            assign slot_we[gi] = accept & (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // Slot contents need no reset: they are only read while counted valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (slot_we[i]) begin
                owner_q[i] <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wen     (data_wen),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner queue, held requester, last winner.
    // ------------------------------------------------------------------
    bit m_owner[$];          // 1 = data
    int m_held;              // 0 none, 1 inst, 2 data
    bit m_last_d;
    bit m_after_rst;
    bit en_m, g_d, g_req, e_req, e_acc, e_pop, e_head;

    always @(negedge clk) begin
        if (!resetn) begin
            m_owner.delete();
            m_held      = 0;
            m_last_d    = 1'b1;
            m_after_rst = 1'b1;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_inst_addr_ok", inst_addr_ok, 0);
            chk("rst_data_addr_ok", data_addr_ok, 0);
            chk("rst_inst_data_ok", inst_data_ok, 0);
            chk("rst_data_data_ok", data_data_ok, 0);
        end else begin
            en_m = !m_after_rst;
            if (m_held == 1) g_d = 1'b0;
            else if (m_held == 2) g_d = 1'b1;
            else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
                g_d = !m_last_d;
`else
                g_d = 1'b1;
`endif
            end else g_d = data_req;
            g_req  = g_d ? data_req : inst_req;
            e_req  = en_m && g_req && (m_owner.size() < OUT);
            e_acc  = e_req && mem_addr_ok;
            e_pop  = en_m && mem_data_ok && (m_owner.size() > 0);
            e_head = e_pop ? m_owner[0] : 1'b0;

            chk("mdl_mem_req", mem_req, e_req);
            chk("mdl_inst_addr_ok", inst_addr_ok, e_acc && !g_d);
            chk("mdl_data_addr_ok", data_addr_ok, e_acc && g_d);
            chk("mdl_inst_data_ok", inst_data_ok, e_pop && !e_head);
            chk("mdl_data_data_ok", data_data_ok, e_pop && e_head);
            if (e_req) begin
                chk("mdl_mem_addr", mem_addr, g_d ? data_addr : inst_addr);
                chk("mdl_mem_wr", mem_wr, g_d ? data_wr : 1'b0);
                chk("mdl_mem_size", mem_size, g_d ? data_size : 2'd2);
                chk("mdl_mem_wen", mem_wen, g_d ? data_wen : 4'd0);
                if (g_d) chk("mdl_mem_wdata", mem_wdata, data_wdata);
            end
            if (e_pop) begin
                if (e_head) chk("mdl_data_rdata", data_rdata, mem_rdata);
                else        chk("mdl_inst_rdata", inst_rdata, mem_rdata);
            end

            if (e_pop) void'(m_owner.pop_front());
            if (e_acc) begin
                m_owner.push_back(g_d);
                m_last_d = g_d;
            end
            if (m_held == 0) begin
                if (e_req && !mem_addr_ok) m_held = g_d ? 2 : 1;
            end else if (e_acc || !g_req) begin
                m_held = 0;
            end
            m_after_rst = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drv(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [1:0] ds,
                       input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd,
                       input logic aok, input logic dok, input logic [31:0] rd);
        inst_req = ir;  inst_addr = ia;
        data_req = dr;  data_wr = dw; data_size = ds; data_addr = da;
        data_wen = dwe; data_wdata = dwd;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    endtask

    // loads / fetch only
    task automatic drl(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic aok, input logic dok,
                       input logic [31:0] rd);
        drv(ir, ia, dr, 1'b0, 2'd2, da, 4'd0, 32'd0, aok, dok, rd);
    endtask

    task automatic ck();
        @(negedge clk); #1;
    endtask

    task automatic nx();
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        drl(0, 0, 0, 0, 0, 0, 0); ck(); nx();
    endtask

    initial begin
        resetn = 1'b0;
        drl(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        // Cycle right after release: request must not go out.
        drl(1, 32'h10, 0, 0, 1, 0, 0); ck();
        chk("post_rst_mem_req", mem_req, 0);
        chk("post_rst_inst_addr_ok", inst_addr_ok, 0);
        nx();
        idle_cycle();

        // ---- Test 1: simultaneous requests ----
        drl(1, 32'h1000, 1, 32'h2000, 1, 0, 0); ck();
`ifdef ARB_RR_EN
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_mem_addr", mem_addr, 32'h1000);
`else
        chk("t1_data_addr_ok", data_addr_ok, 1);
        chk("t1_inst_addr_ok", inst_addr_ok, 0);
        chk("t1_mem_addr", mem_addr, 32'h2000);
`endif
        nx();
        drl(1, 32'h1000, 0, 0, 1, 0, 0); ck();
        chk("t1_inst_next", inst_addr_ok, 1);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h11); ck();
`ifndef ARB_RR_EN
        chk("t1_first_resp_data", data_data_ok, 1);
        chk("t1_first_rdata", data_rdata, 32'h11);
`endif
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h22); ck();
`ifndef ARB_RR_EN
        chk("t1_second_resp_inst", inst_data_ok, 1);
`endif
        nx();

        // ---- Test 2: HOLD_I is not preempted ----
        drl(1, 32'h40, 0, 0, 0, 0, 0); ck();
        chk("t2_c1_mem_addr", mem_addr, 32'h40);
        nx();
        for (int k = 0; k < 2; k++) begin
            drl(1, 32'h40, 1, 32'h80, 0, 0, 0); ck();
            chk("t2_hold_mem_addr", mem_addr, 32'h40);
            chk("t2_hold_mem_req", mem_req, 1);
            nx();
        end
        drl(1, 32'h40, 1, 32'h80, 1, 0, 0); ck();
        chk("t2_inst_acc", inst_addr_ok, 1);
        chk("t2_data_not_acc", data_addr_ok, 0);
        nx();
        drl(0, 0, 1, 32'h80, 1, 0, 0); ck();
        chk("t2_data_acc", data_addr_ok, 1);
        chk("t2_data_mem_addr", mem_addr, 32'h80);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h33); ck();
        chk("t2_resp_inst", inst_data_ok, 1);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h44); ck();
        chk("t2_resp_data", data_data_ok, 1);
        nx();

        // ---- Test 3: FIFO full blocks the third request ----
        drl(1, 32'h300, 0, 0, 1, 0, 0); ck(); nx();
        drl(1, 32'h304, 0, 0, 1, 0, 0); ck(); nx();
        drl(1, 32'h308, 0, 0, 1, 0, 0); ck();
        chk("t3_full_mem_req", mem_req, 0);
        chk("t3_full_addr_ok", inst_addr_ok, 0);
        nx();
        drl(1, 32'h308, 0, 0, 1, 1, 32'h5555); ck();
        chk("t3_pop_inst_data_ok", inst_data_ok, 1);
        chk("t3_pop_rdata", inst_rdata, 32'h5555);
        chk("t3_pop_mem_req", mem_req, 0);
        nx();
        drl(1, 32'h308, 0, 0, 1, 0, 0); ck();
        chk("t3_issue_mem_req", mem_req, 1);
        chk("t3_issue_addr_ok", inst_addr_ok, 1);
        chk("t3_issue_addr", mem_addr, 32'h308);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h1); ck(); nx();
        drl(0, 0, 0, 0, 0, 1, 32'h2); ck(); nx();

        // ---- Test 4: in-order routing ----
        drl(0, 0, 1, 32'h100, 1, 0, 0); ck();
        chk("t4_data_acc", data_addr_ok, 1);
        nx();
        drl(1, 32'h200, 0, 0, 1, 0, 0); ck();
        chk("t4_inst_acc", inst_addr_ok, 1);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'hAAAA); ck();
        chk("t4_data_data_ok", data_data_ok, 1);
        chk("t4_inst_quiet", inst_data_ok, 0);
        chk("t4_data_rdata", data_rdata, 32'hAAAA);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'hBBBB); ck();
        chk("t4_inst_data_ok", inst_data_ok, 1);
        chk("t4_inst_rdata", inst_rdata, 32'hBBBB);
        nx();

        // ---- Store accepted in the same cycle as a response ----
        drl(1, 32'h400, 0, 0, 1, 0, 0); ck(); nx();
        drv(0, 0, 1, 1, 2'd1, 32'h502, 4'b1100, 32'hDEADBEEF, 1, 1, 32'h1234); ck();
        chk("st_same_inst_data_ok", inst_data_ok, 1);
        chk("st_same_data_data_ok", data_data_ok, 0);
        chk("st_addr_ok", data_addr_ok, 1);
        chk("st_mem_wr", mem_wr, 1);
        chk("st_mem_size", mem_size, 2'd1);
        chk("st_mem_wen", mem_wen, 4'b1100);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h0); ck();
        chk("st_done", data_data_ok, 1);
        nx();

        // ---- HOLD_D released by data_req dropping ----
        drl(0, 0, 1, 32'h600, 0, 0, 0); ck();
        chk("hd_mem_req", mem_req, 1);
        nx();
        drl(1, 32'h700, 0, 0, 0, 0, 0); ck();
        chk("hd_drop_mem_req", mem_req, 0);
        nx();
        drl(1, 32'h700, 0, 0, 1, 0, 0); ck();
        chk("hd_inst_acc", inst_addr_ok, 1);
        chk("hd_inst_addr", mem_addr, 32'h700);
        chk("hd_inst_size", mem_size, 2'd2);
        chk("hd_inst_wr", mem_wr, 0);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h5); ck();
        chk("hd_inst_resp", inst_data_ok, 1);
        nx();

        // ---- Test 5: reset with two outstanding ----
        drl(1, 32'h800, 0, 0, 1, 0, 0); ck(); nx();
        drl(1, 32'h804, 0, 0, 1, 0, 0); ck(); nx();
        resetn = 1'b0;
        drl(0, 0, 0, 0, 0, 0, 0); ck(); nx();
        resetn = 1'b1;
        drl(0, 0, 0, 0, 0, 1, 32'h99); ck();
        chk("t5_stray1_inst", inst_data_ok, 0);
        chk("t5_stray1_data", data_data_ok, 0);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h98); ck();
        chk("t5_stray2_inst", inst_data_ok, 0);
        nx();
        drl(1, 32'h900, 0, 0, 1, 0, 0); ck();
        chk("t5_new_acc", inst_addr_ok, 1);
        nx();
        drl(0, 0, 0, 0, 0, 1, 32'h77); ck();
        chk("t5_new_resp", inst_data_ok, 1);
        nx();

        // ---- Test 6: continuous contention after a fresh reset ----
        resetn = 1'b0;
        drl(0, 0, 0, 0, 0, 0, 0); ck(); nx();
        resetn = 1'b1;
        idle_cycle();
        for (int k = 0; k < 4; k++) begin
            drl(1, 32'hA00 + 32'(k * 4), 1, 32'hB00 + 32'(k * 4), 1, 1, 32'(k)); ck();
`ifdef ARB_RR_EN
            chk("t6_inst_grant", inst_addr_ok, (k % 2) == 0);
            chk("t6_data_grant", data_addr_ok, (k % 2) == 1);
`else
            chk("t6_inst_grant", inst_addr_ok, 0);
            chk("t6_data_grant", data_addr_ok, 1);
`endif
            nx();
        end
        drl(0, 0, 0, 0, 0, 1, 32'h0); ck(); nx();
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
